// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/stall unit: debug-FSM states and forwarding selects.
package hazard_pkg;

  typedef enum logic [1:0] {
    DBG_RUN  = 2'd0,
    DBG_HOLD = 2'd1,
    DBG_STEP = 2'd2,
    DBG_HALT = 2'd3
  } dbgState_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

endpackage

// File: rtl/hazard_dbg_fsm.sv
// Sequential side of the hazard unit: sticky trap halt, single-step debug FSM,
// step_req edge detector and the fixed-latency memory-wait counter.
module hazard_dbg_fsm
  import hazard_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_rd_start,
  input  logic mem_busy,
  input  logic trap,
  input  logic step_en,
  input  logic step_req,
  output logic freeze,
  output logic halted
);

  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(MEM_WAIT);

  dbgState_t     state;
  logic          stepPrev;
  logic [CW-1:0] cnt;
  logic          memWait;
  logic          stepEdge;

  assign memWait  = (cnt != '0) | mem_busy;
  assign stepEdge = step_req & ~stepPrev;
  assign freeze   = (state == DBG_HALT) | (state == DBG_HOLD) | memWait;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DBG_RUN;
      stepPrev <= 1'b0;
      cnt      <= '0;
      halted   <= 1'b0;
    end else begin
      stepPrev <= step_req;

      // A start while a wait is already counting is dropped, not queued.
      if (mem_rd_start && cnt == '0)
        cnt <= WAIT_LOAD;
      else if (cnt != '0)
        cnt <= cnt - CW'(1);

      if (trap) begin
        state  <= DBG_HALT;
        halted <= 1'b1;
      end else begin
        unique case (state)
          DBG_RUN:  if (step_en) state <= DBG_HOLD;
          DBG_HOLD: begin
            if (!step_en)     state <= DBG_RUN;
            else if (stepEdge) state <= DBG_STEP;
          end
          DBG_STEP: if (!memWait) state <= step_en ? DBG_HOLD : DBG_RUN;
          default:  state <= DBG_HALT;
        endcase
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall unit for the 5-stage pipeline: load-use and decode-branch/jr stalls,
// decode and execute forwarding selects, control flush, and debug/memory freeze.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int MEM_WAIT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*REG_AW-1:0] src_d,
  input  logic [NUM_SRC-1:0]        src_used_d,
  input  logic [NUM_SRC*REG_AW-1:0] src_e,
  input  logic                      branch_d,
  input  logic                      jr_d,
  input  logic                      pc_src_d,
  input  logic                      jump_d,
  input  logic [REG_AW-1:0]         rd_e,
  input  logic [REG_AW-1:0]         rd_m,
  input  logic [REG_AW-1:0]         rd_w,
  input  logic                      reg_write_e,
  input  logic                      reg_write_m,
  input  logic                      reg_write_w,
  input  logic                      mem_to_reg_e,
  input  logic                      mem_to_reg_m,
  input  logic                      mem_rd_start,
  input  logic                      mem_busy,
  input  logic                      trap,
  input  logic                      step_en,
  input  logic                      step_req,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic                      freeze,
  output logic [NUM_SRC-1:0]        fwd_d,
  output logic [2*NUM_SRC-1:0]      fwd_e,
  output logic                      halted
);

  logic                 fsmFreeze;
  logic                 fsmHalted;
  logic [NUM_SRC-1:0]   eMatchD;
  logic [NUM_SRC-1:0]   mMatchD;
  logic [NUM_SRC-1:0]   fwdD;
  logic [2*NUM_SRC-1:0] fwdE;
  logic                 loadE;
  logic                 loadM;
  logic                 luStall;

  hazard_dbg_fsm #(.MEM_WAIT(MEM_WAIT)) u_dbg (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_rd_start (mem_rd_start),
    .mem_busy     (mem_busy),
    .trap         (trap),
    .step_en      (step_en),
    .step_req     (step_req),
    .freeze       (fsmFreeze),
    .halted       (fsmHalted)
  );

  // Register 0 is hardwired, so a zero destination never matches.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_slot
    logic [REG_AW-1:0] sd;
    logic [REG_AW-1:0] se;
    assign sd = src_d[gi*REG_AW +: REG_AW];
    assign se = src_e[gi*REG_AW +: REG_AW];

    assign eMatchD[gi] = (sd == rd_e) && (rd_e != '0);
    assign mMatchD[gi] = (sd == rd_m) && (rd_m != '0);
    assign fwdD[gi]    = reg_write_m & mMatchD[gi];

    always_comb begin
      if (reg_write_m && se == rd_m && rd_m != '0)
        fwdE[2*gi +: 2] = FWD_M;
      else if (reg_write_w && se == rd_w && rd_w != '0)
        fwdE[2*gi +: 2] = FWD_W;
      else
        fwdE[2*gi +: 2] = FWD_RF;
    end
  end

  assign loadE = reg_write_e & mem_to_reg_e;
  assign loadM = reg_write_m & mem_to_reg_m;

  // jr always reads slot 0, so its hazard ignores the used mask.
  assign luStall = (loadE & |(eMatchD & src_used_d))
                 | (branch_d & ((reg_write_e & |(eMatchD & src_used_d))
                              | (loadM & |(mMatchD & src_used_d))))
                 | (jr_d & ((reg_write_e & eMatchD[0]) | (reg_write_m & mMatchD[0])));

  // Outputs are forced low while rst_n is asserted, even though most are
  // combinational from datapath inputs.
  assign freeze = rst_n & fsmFreeze;
  assign halted = rst_n & fsmHalted;
  assign fwd_d  = rst_n ? fwdD : '0;
  assign fwd_e  = rst_n ? fwdE : '0;

  // NOTE: every output gets a default first so no path through the
  // priority chain leaves a value unassigned and infers a latch.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (!rst_n || fsmFreeze) begin
      // freeze holds the whole pipe by itself
    end else if (luStall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      flush_d = pc_src_d | jump_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic against
// a behavioural model; a negedge monitor compares DUT outputs to queued expectations.
module tb_hazard_ctrl;

  localparam int REG_AW   = 5;
  localparam int NUM_SRC  = 2;
  localparam int MEM_WAIT = 2;
  localparam int OW       = 6 + 3 * NUM_SRC;

  logic clk = 1'b1;
  logic rst_n;
  logic [NUM_SRC*REG_AW-1:0] src_d, src_e;
  logic [NUM_SRC-1:0] src_used_d;
  logic branch_d, jr_d, pc_src_d, jump_d;
  logic [REG_AW-1:0] rd_e, rd_m, rd_w;
  logic reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
  logic mem_rd_start, mem_busy, trap, step_en, step_req;
  logic stall_f, stall_d, flush_d, flush_e, freeze, halted;
  logic [NUM_SRC-1:0] fwd_d;
  logic [2*NUM_SRC-1:0] fwd_e;

  int nTests = 0;
  int nFail  = 0;
  logic [OW-1:0] expQ[$];

  // Reference-model state
  int memLeft;
  bit mHalt, mHold, mStep, mPrevReq;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .src_d(src_d), .src_used_d(src_used_d), .src_e(src_e),
    .branch_d(branch_d), .jr_d(jr_d), .pc_src_d(pc_src_d), .jump_d(jump_d),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .mem_rd_start(mem_rd_start), .mem_busy(mem_busy), .trap(trap),
    .step_en(step_en), .step_req(step_req),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .freeze(freeze), .fwd_d(fwd_d), .fwd_e(fwd_e), .halted(halted)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic bit m(input int a, input int b);
    return (a == b) && (b != 0);
  endfunction

  function automatic int sd(input int i);
    return int'(src_d[i*REG_AW +: REG_AW]);
  endfunction

  function automatic int se(input int i);
    return int'(src_e[i*REG_AW +: REG_AW]);
  endfunction

  // Expected {halted, freeze, stall_f, stall_d, flush_d, flush_e, fwd_d, fwd_e}
  function automatic logic [OW-1:0] model_expect();
    bit frz, lu, sf, sdl, fdl, fel;
    logic [NUM_SRC-1:0] fd;
    logic [2*NUM_SRC-1:0] fe;
    if (!rst_n) return '0;
    frz = mHalt || mHold || (memLeft > 0) || mem_busy;
    lu = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_used_d[i]) begin
        if (reg_write_e && mem_to_reg_e && m(sd(i), int'(rd_e))) lu = 1;
        if (branch_d && reg_write_e && m(sd(i), int'(rd_e))) lu = 1;
        if (branch_d && reg_write_m && mem_to_reg_m && m(sd(i), int'(rd_m))) lu = 1;
      end
    end
    if (jr_d && ((reg_write_e && m(sd(0), int'(rd_e))) || (reg_write_m && m(sd(0), int'(rd_m)))))
      lu = 1;
    sf = 0; sdl = 0; fdl = 0; fel = 0;
    if (frz) ;
    else if (lu) begin sf = 1; sdl = 1; fel = 1; end
    else fdl = pc_src_d | jump_d;
    for (int i = 0; i < NUM_SRC; i++) begin
      fd[i] = reg_write_m && m(sd(i), int'(rd_m));
      if (reg_write_m && m(se(i), int'(rd_m)))      fe[2*i +: 2] = 2'b10;
      else if (reg_write_w && m(se(i), int'(rd_w))) fe[2*i +: 2] = 2'b01;
      else                                          fe[2*i +: 2] = 2'b00;
    end
    return {mHalt, frz, sf, sdl, fdl, fel, fd, fe};
  endfunction

  task automatic model_update();
    bit busy, rise;
    if (!rst_n) begin
      memLeft = 0; mHalt = 0; mHold = 0; mStep = 0; mPrevReq = 0;
      return;
    end
    busy = (memLeft > 0) || mem_busy;
    rise = step_req && !mPrevReq;
    mPrevReq = step_req;
    if (trap) begin
      mHalt = 1; mHold = 0; mStep = 0;
    end else if (!mHalt) begin
      if (mStep) begin
        if (!busy) begin mStep = 0; mHold = step_en; end
      end else if (mHold) begin
        if (!step_en) mHold = 0;
        else if (rise) begin mHold = 0; mStep = 1; end
      end else if (step_en) mHold = 1;
    end
    if (mem_rd_start && memLeft == 0) memLeft = MEM_WAIT;
    else if (memLeft > 0) memLeft--;
  endtask

  // One cycle: queue the expectation, cross the edge, advance the model.
  task automatic tick();
    expQ.push_back(model_expect());
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_ins();
    src_d = '0; src_e = '0; src_used_d = '0;
    branch_d = 0; jr_d = 0; pc_src_d = 0; jump_d = 0;
    rd_e = '0; rd_m = '0; rd_w = '0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_to_reg_e = 0; mem_to_reg_m = 0;
    mem_rd_start = 0; mem_busy = 0; trap = 0; step_en = 0; step_req = 0;
  endtask

  task automatic rand_ins();
    for (int i = 0; i < NUM_SRC; i++) begin
      src_d[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
      src_e[i*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
    end
    src_used_d = NUM_SRC'($urandom);
    rd_e = REG_AW'($urandom_range(0, 3));
    rd_m = REG_AW'($urandom_range(0, 3));
    rd_w = REG_AW'($urandom_range(0, 3));
    {reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m} = 5'($urandom);
    {branch_d, jr_d, pc_src_d, jump_d} = 4'($urandom);
    if (jr_d) src_used_d[0] = 1'b1;
    mem_rd_start = ($urandom_range(0, 5) == 0);
    mem_busy     = ($urandom_range(0, 7) == 0);
    step_en      = ($urandom_range(0, 9) == 0);
    step_req     = 1'($urandom);
    trap         = 0;
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      logic [OW-1:0] e;
      e = expQ.pop_front();
      check("outputs{halt,frz,sf,sd,fd,fe,fwd_d,fwd_e}",
            32'({halted, freeze, stall_f, stall_d, flush_d, flush_e, fwd_d, fwd_e}), 32'(e));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    clear_ins();
    rst_n = 0;
    mem_busy = 1;
    model_update();
    tick();                                   // reset state, busy ignored
    rst_n = 1;
    clear_ins();
    tick();

    // Load-use: lw r8 in E, add uses r8
    rd_e = 5'd8; reg_write_e = 1; mem_to_reg_e = 1;
    src_d = {5'd2, 5'd8}; src_used_d = 2'b11;
    tick();
    src_used_d = 2'b10;                       // slot holding r8 unused
    tick();
    clear_ins();
    reg_write_e = 1; mem_to_reg_e = 1; src_used_d = 2'b11;   // r0 never matches
    tick();

    // Execute forwarding, M beats W
    clear_ins();
    rd_m = 5'd5; rd_w = 5'd5; reg_write_m = 1; reg_write_w = 1;
    src_e = {5'd5, 5'd7};
    tick();
    reg_write_m = 0;
    tick();

    // beq r3,r4 with addi r4 in E, then taken with forward from M
    clear_ins();
    branch_d = 1; src_d = {5'd4, 5'd3}; src_used_d = 2'b11;
    rd_e = 5'd4; reg_write_e = 1;
    tick();
    rd_e = 5'd0; reg_write_e = 0; rd_m = 5'd4; reg_write_m = 1; pc_src_d = 1;
    tick();

    // Memory wait: two frozen cycles, mid-wait start ignored
    clear_ins();
    mem_rd_start = 1; tick();
    mem_rd_start = 1; tick();
    mem_rd_start = 0; tick();
    tick();

    // Single step
    clear_ins();
    step_en = 1;
    repeat (3) tick();
    step_req = 1;
    repeat (5) tick();
    step_req = 0; tick();
    step_req = 1; mem_busy = 1; repeat (3) tick();
    mem_busy = 0; repeat (2) tick();
    step_en = 0; step_req = 0; repeat (2) tick();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      rand_ins();
      tick();
    end

    // Trap during memory wait is sticky
    clear_ins();
    repeat (3) tick();
    mem_rd_start = 1; tick();
    mem_rd_start = 0; trap = 1; tick();
    trap = 0;
    for (int n = 0; n < 6; n++) begin
      rand_ins();
      step_en = 1'($urandom);
      tick();
    end

    // Mid-run asynchronous reset
    rst_n = 0;
    #1;
    check("reset_halted_now", 32'(halted), 32'(0));
    check("reset_freeze_now", 32'(freeze), 32'(0));
    check("reset_stall_now", 32'(stall_f | stall_d | flush_d | flush_e), 32'(0));
    tick();
    rst_n = 1;
    clear_ins();
    repeat (3) tick();

    #10;
    check("queue_drained", 32'(expQ.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
